// File: rtl/time_code_generator.sv
// Wall-clock hour/minute counter with a registered one-hot day-phase code for the lighting system.
// Latency: a load or tick is visible on the next clk edge; tcode and tcode_chg update on that same edge.
// Backpressure: none; set_en wins over tick_min, and every request gets a one-cycle set_ack or set_err.
module time_code_generator #(
    parameter int MORNING_START = 6,
    parameter int NOON_START    = 12,
    parameter int EVENING_START = 17,
    parameter int NIGHT_START   = 21
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_min,
    input  logic       set_en,
    input  logic [4:0] set_hour,
    input  logic [5:0] set_min,
    output logic       set_ack,
    output logic       set_err,
    output logic [4:0] hour,
    output logic [5:0] minute,
    output logic [3:0] tcode,
    output logic       tcode_chg
);

    localparam logic [3:0] PH_MORNING = 4'b0001;
    localparam logic [3:0] PH_NOON    = 4'b0010;
    localparam logic [3:0] PH_EVENING = 4'b0100;
    localparam logic [3:0] PH_NIGHT   = 4'b1000;

    logic [4:0] hour_nxt;
    logic [5:0] minute_nxt;
    logic [3:0] tcode_nxt;
    logic       load_ok;
    logic       load_bad;

    // Map an hour to its day phase; anything outside the three daytime bands is night.
    function automatic logic [3:0] phase_of(input logic [4:0] h);
        int hv;
        hv = int'(h);
        if (hv >= MORNING_START && hv < NOON_START) begin
            phase_of = PH_MORNING;
        end else if (hv >= NOON_START && hv < EVENING_START) begin
            phase_of = PH_NOON;
        end else if (hv >= EVENING_START && hv < NIGHT_START) begin
            phase_of = PH_EVENING;
        end else begin
            phase_of = PH_NIGHT;
        end
    endfunction

    // Next time: a load request (valid or not) takes priority and swallows a same-cycle tick.
    always_comb begin
        hour_nxt   = hour;
        minute_nxt = minute;
        load_ok    = 1'b0;
        load_bad   = 1'b0;
        if (set_en) begin
            if (set_hour <= 5'd23 && set_min <= 6'd59) begin
                load_ok    = 1'b1;
                hour_nxt   = set_hour;
                minute_nxt = set_min;
            end else begin
                load_bad = 1'b1;
            end
        end else if (tick_min) begin
            if (minute == 6'd59) begin
                minute_nxt = 6'd0;
                hour_nxt   = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
            end else begin
                minute_nxt = minute + 6'd1;
            end
        end
        tcode_nxt = phase_of(hour_nxt);
    end

    // Time, handshake pulses and phase code; tcode leaves its all-zero reset value on the first edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hour      <= 5'd0;
            minute    <= 6'd0;
            tcode     <= 4'b0000;
            tcode_chg <= 1'b0;
            set_ack   <= 1'b0;
            set_err   <= 1'b0;
        end else begin
            hour      <= hour_nxt;
            minute    <= minute_nxt;
            tcode     <= tcode_nxt;
            tcode_chg <= (tcode_nxt != tcode);
            set_ack   <= load_ok;
            set_err   <= load_bad;
        end
    end

endmodule

// File: tb/tb_time_code_generator.sv
// Directed bench for time_code_generator: reset, loads, rejects, wraps, phase changes, full-day walk.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: none.
module tb_time_code_generator;

    logic       clk;
    logic       rst;
    logic       tick_min;
    logic       set_en;
    logic [4:0] set_hour;
    logic [5:0] set_min;
    logic       set_ack;
    logic       set_err;
    logic [4:0] hour;
    logic [5:0] minute;
    logic [3:0] tcode;
    logic       tcode_chg;

    int vectors;
    int miscompares;
    int nchg;
    int chg_hours[4];

    time_code_generator dut (
        .clk       (clk),
        .rst       (rst),
        .tick_min  (tick_min),
        .set_en    (set_en),
        .set_hour  (set_hour),
        .set_min   (set_min),
        .set_ack   (set_ack),
        .set_err   (set_err),
        .hour      (hour),
        .minute    (minute),
        .tcode     (tcode),
        .tcode_chg (tcode_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [4:0] h, input logic [5:0] m,
                           input logic [3:0] tc, input logic chg, input logic ack, input logic err);
        chk({tag, ".hour"},      32'(hour),      32'(h));
        chk({tag, ".minute"},    32'(minute),    32'(m));
        chk({tag, ".tcode"},     32'(tcode),     32'(tc));
        chk({tag, ".tcode_chg"}, 32'(tcode_chg), 32'(chg));
        chk({tag, ".set_ack"},   32'(set_ack),   32'(ack));
        chk({tag, ".set_err"},   32'(set_err),   32'(err));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        nchg        = 0;
        rst         = 1'b1;
        tick_min    = 1'b0;
        set_en      = 1'b0;
        set_hour    = 5'd0;
        set_min     = 6'd0;

        // Held in reset with stimulus active: outputs stay at reset values.
        #12;
        set_en   = 1'b1;
        set_hour = 5'd9;
        set_min  = 6'd30;
        tick_min = 1'b1;
        step();
        chk_all("in_reset", 5'd0, 6'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
        set_en   = 1'b0;
        tick_min = 1'b0;
        rst      = 1'b0;
        #1;
        chk("release.tcode_zero", 32'(tcode), 32'(4'b0000));

        // First edge after release loads night and pulses tcode_chg once.
        step();
        chk_all("rel_cyc1", 5'd0, 6'd0, 4'b1000, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("rel_cyc2", 5'd0, 6'd0, 4'b1000, 1'b0, 1'b0, 1'b0);

        // Load 05:59 then tick into the morning phase.
        set_en = 1'b1; set_hour = 5'd5; set_min = 6'd59;
        step();
        set_en = 1'b0;
        chk_all("load_0559", 5'd5, 6'd59, 4'b1000, 1'b0, 1'b1, 1'b0);
        tick_min = 1'b1;
        step();
        tick_min = 1'b0;
        chk_all("tick_0600", 5'd6, 6'd0, 4'b0001, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("hold_0600", 5'd6, 6'd0, 4'b0001, 1'b0, 1'b0, 1'b0);

        // Load 23:59 (morning -> night) then wrap past midnight without a phase change.
        set_en = 1'b1; set_hour = 5'd23; set_min = 6'd59;
        step();
        set_en = 1'b0;
        chk_all("load_2359", 5'd23, 6'd59, 4'b1000, 1'b1, 1'b1, 1'b0);
        tick_min = 1'b1;
        step();
        tick_min = 1'b0;
        chk_all("wrap_0000", 5'd0, 6'd0, 4'b1000, 1'b0, 1'b0, 1'b0);

        // Rejected loads: hour 24, then minute 60 with a colliding tick that must be discarded.
        set_en = 1'b1; set_hour = 5'd24; set_min = 6'd0;
        step();
        set_en = 1'b0;
        chk_all("rej_h24", 5'd0, 6'd0, 4'b1000, 1'b0, 1'b0, 1'b1);
        step();
        chk("rej_h24.err_clear", 32'(set_err), 32'(1'b0));
        set_en = 1'b1; set_hour = 5'd3; set_min = 6'd60; tick_min = 1'b1;
        step();
        set_en = 1'b0; tick_min = 1'b0;
        chk_all("rej_m60_tick", 5'd0, 6'd0, 4'b1000, 1'b0, 1'b0, 1'b1);
        step();
        chk_all("rej_m60_after", 5'd0, 6'd0, 4'b1000, 1'b0, 1'b0, 1'b0);

        // Load 16:59 with a simultaneous tick: load wins, then tick into evening.
        set_en = 1'b1; set_hour = 5'd16; set_min = 6'd59; tick_min = 1'b1;
        step();
        set_en = 1'b0; tick_min = 1'b0;
        chk_all("load_1659_tick", 5'd16, 6'd59, 4'b0010, 1'b1, 1'b1, 1'b0);
        tick_min = 1'b1;
        step();
        tick_min = 1'b0;
        chk_all("tick_1700", 5'd17, 6'd0, 4'b0100, 1'b1, 1'b0, 1'b0);

        // Full day from 00:00: exactly four phase changes at 6, 12, 17, 21.
        set_en = 1'b1; set_hour = 5'd0; set_min = 6'd0;
        step();
        set_en = 1'b0;
        chk_all("load_0000", 5'd0, 6'd0, 4'b1000, 1'b1, 1'b1, 1'b0);
        step();
        tick_min = 1'b1;
        for (int i = 0; i < 1440; i++) begin
            step();
            if (tcode_chg) begin
                if (nchg < 4) chg_hours[nchg] = int'(hour);
                nchg++;
            end
        end
        tick_min = 1'b0;
        chk("day.chg_count", 32'(nchg), 32'd4);
        chk("day.chg0_hour", 32'(chg_hours[0]), 32'd6);
        chk("day.chg1_hour", 32'(chg_hours[1]), 32'd12);
        chk("day.chg2_hour", 32'(chg_hours[2]), 32'd17);
        chk("day.chg3_hour", 32'(chg_hours[3]), 32'd21);
        chk("day.end_hour", 32'(hour), 32'd0);
        chk("day.end_minute", 32'(minute), 32'd0);

        // Move to 10:10, then assert reset mid-cycle during a pending load.
        set_en = 1'b1; set_hour = 5'd10; set_min = 6'd10;
        step();
        chk_all("load_1010", 5'd10, 6'd10, 4'b0001, 1'b1, 1'b1, 1'b0);
        set_hour = 5'd20; set_min = 6'd20; tick_min = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 5'd0, 6'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("rst_hold", 5'd0, 6'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
        set_en = 1'b0; tick_min = 1'b0;
        rst = 1'b0;
        step();
        chk_all("rerelease", 5'd0, 6'd0, 4'b1000, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
